// File: rtl/lidar_frame_sequencer_pkg.sv
// Shared definitions for the lidar spectral processing chain: default widths
// and the sequencer state encoding used by the phase blocks and register decode.
package lidar_frame_sequencer_pkg;

  localparam int LFS_PULSE_W   = 16;
  localparam int LFS_BIN_W     = 5;
  localparam int LFS_NUM_BINS  = 16;
  localparam int LFS_TIMEOUT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_BG      = 3'd2,
    ST_PEAK    = 3'd3,
    ST_DONE    = 3'd4
  } lfs_state_e;

  // Phases that wait on an external done pulse and are therefore watched.
  function automatic logic lfs_is_watched(input lfs_state_e s);
    return (s == ST_CAPTURE) || (s == ST_BG) || (s == ST_PEAK);
  endfunction

endpackage

// File: rtl/lidar_frame_sequencer_seq_watchdog.sv
// Per-phase watchdog. Counts enabled cycles since the last clear; expired_o
// is raised during the (2^TIMEOUT_W - 1)-th enabled cycle after a clear, so
// the sequencer leaves the phase on the edge that closes that cycle.
module seq_watchdog
  import lidar_frame_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = LFS_TIMEOUT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Counter value seen during the last allowed cycle of a phase.
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] r_cnt;

  // Cycle counter: clear has priority over counting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  assign expired_o = en_i && (r_cnt == LP_LAST);

endmodule

// File: rtl/lidar_frame_sequencer.sv
// Frame sequencer: capture/accumulate -> optional background deduction ->
// per-bin peak detection, advanced by done handshakes and guarded by a
// per-phase watchdog. Phase enables are registered from the next state so
// they change on the same edge as state_o and are never simultaneously high.
// Handshake: each *_done_i is a single-cycle strobe, accepted only in the
// state that owns it; start_i is accepted only in IDLE; abort_i always wins.
module lidar_frame_sequencer
  import lidar_frame_sequencer_pkg::*;
#(
  parameter int PULSE_W   = LFS_PULSE_W,
  parameter int BIN_W     = LFS_BIN_W,
  parameter int NUM_BINS  = LFS_NUM_BINS,
  parameter int TIMEOUT_W = LFS_TIMEOUT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [PULSE_W-1:0] cfg_pulses_i,
  input  logic [BIN_W-1:0]   cfg_bins_i,
  input  logic               cfg_bg_en_i,
  input  logic               cfg_cont_i,
  input  logic               acc_done_i,
  input  logic               bg_done_i,
  input  logic               pd_bin_done_i,
  output logic               capture_en_o,
  output logic               spec_acc_ctrl_o,
  output logic               bg_deduction_en_o,
  output logic               peak_detection_en_o,
  output logic [BIN_W-1:0]   pd_bin_o,
  output logic [PULSE_W-1:0] pulse_count_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               error_o,
  output logic [2:0]         state_o
);

  localparam logic [BIN_W:0] LP_MAX_BINS = (BIN_W + 1)'(NUM_BINS);

  lfs_state_e         r_state;
  lfs_state_e         w_nxt_state;
  logic [PULSE_W-1:0] r_pulse_cnt;
  logic [PULSE_W-1:0] w_nxt_pulse_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [BIN_W-1:0]   w_nxt_bin;
  logic               r_error;
  logic               w_nxt_error;
  logic               w_latch_cfg;

  logic [PULSE_W-1:0] r_cfg_pulses;
  logic [BIN_W-1:0]   r_cfg_bins;
  logic               r_cfg_bg_en;

  logic               r_capture_en;
  logic               r_spec_acc;
  logic               r_bg_en;
  logic               r_peak_en;
  logic               r_busy;
  logic               r_frame_done;

  logic               w_cfg_legal;
  logic [PULSE_W-1:0] w_pulse_inc;
  logic               w_last_bin;
  logic               w_done_accepted;
  logic               w_wd_clr;
  logic               w_wd_en;
  logic               w_wd_expired;

  assign w_cfg_legal = (cfg_pulses_i != '0) && (cfg_bins_i != '0) &&
                       ({1'b0, cfg_bins_i} <= LP_MAX_BINS);
  assign w_pulse_inc = r_pulse_cnt + PULSE_W'(1);
  assign w_last_bin  = (r_bin == (r_cfg_bins - BIN_W'(1)));

  assign w_done_accepted = ((r_state == ST_CAPTURE) && acc_done_i) ||
                           ((r_state == ST_BG)      && bg_done_i)  ||
                           ((r_state == ST_PEAK)    && pd_bin_done_i);

  // Watchdog restarts on every state entry and on every accepted done.
  assign w_wd_clr = (w_nxt_state != r_state) || w_done_accepted;
  assign w_wd_en  = lfs_is_watched(r_state);

  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_wd_clr),
    .en_i      (w_wd_en),
    .expired_o (w_wd_expired)
  );

  // Next-state and counter update: abort > watchdog expiry > done pulses.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_pulse_cnt = r_pulse_cnt;
    w_nxt_bin       = r_bin;
    w_nxt_error     = r_error;
    w_latch_cfg     = 1'b0;

    if (abort_i) begin
      w_nxt_state = ST_IDLE;
    end else if (w_wd_expired) begin
      w_nxt_state = ST_IDLE;
      w_nxt_error = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (w_cfg_legal) begin
              w_latch_cfg     = 1'b1;
              w_nxt_pulse_cnt = '0;
              w_nxt_bin       = '0;
              w_nxt_error     = 1'b0;
              w_nxt_state     = ST_CAPTURE;
            end else begin
              w_nxt_error = 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (acc_done_i) begin
            w_nxt_pulse_cnt = w_pulse_inc;
            if (w_pulse_inc == r_cfg_pulses) begin
              w_nxt_state = r_cfg_bg_en ? ST_BG : ST_PEAK;
            end
          end
        end
        ST_BG: begin
          if (bg_done_i) begin
            w_nxt_state = ST_PEAK;
          end
        end
        ST_PEAK: begin
          if (pd_bin_done_i) begin
            if (w_last_bin) begin
              w_nxt_state = ST_DONE;
            end else begin
              w_nxt_bin = r_bin + BIN_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (cfg_cont_i) begin
            w_nxt_pulse_cnt = '0;
            w_nxt_bin       = '0;
            w_nxt_state     = ST_CAPTURE;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, error flag and registered phase outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_pulse_cnt  <= '0;
      r_bin        <= '0;
      r_error      <= 1'b0;
      r_capture_en <= 1'b0;
      r_spec_acc   <= 1'b0;
      r_bg_en      <= 1'b0;
      r_peak_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_pulse_cnt  <= w_nxt_pulse_cnt;
      r_bin        <= w_nxt_bin;
      r_error      <= w_nxt_error;
      r_capture_en <= (w_nxt_state == ST_CAPTURE);
      r_spec_acc   <= (w_nxt_state == ST_CAPTURE) && (w_nxt_pulse_cnt != '0);
      r_bg_en      <= (w_nxt_state == ST_BG);
      r_peak_en    <= (w_nxt_state == ST_PEAK);
      r_busy       <= (w_nxt_state != ST_IDLE);
      r_frame_done <= (w_nxt_state == ST_DONE);
    end
  end

  // Frame configuration, captured once per accepted start and reused in
  // continuous mode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cfg_pulses <= '0;
      r_cfg_bins   <= '0;
      r_cfg_bg_en  <= 1'b0;
    end else if (w_latch_cfg) begin
      r_cfg_pulses <= cfg_pulses_i;
      r_cfg_bins   <= cfg_bins_i;
      r_cfg_bg_en  <= cfg_bg_en_i;
    end
  end

  assign capture_en_o        = r_capture_en;
  assign spec_acc_ctrl_o     = r_spec_acc;
  assign bg_deduction_en_o   = r_bg_en;
  assign peak_detection_en_o = r_peak_en;
  assign pd_bin_o            = r_bin;
  assign pulse_count_o       = r_pulse_cnt;
  assign busy_o              = r_busy;
  assign frame_done_o        = r_frame_done;
  assign error_o             = r_error;
  assign state_o             = r_state;

endmodule

// File: tb/tb_lidar_frame_sequencer.sv
// Directed bench for lidar_frame_sequencer with a short watchdog.
module tb_lidar_frame_sequencer;

  localparam int PULSE_W   = 16;
  localparam int BIN_W     = 5;
  localparam int NUM_BINS  = 16;
  localparam int TIMEOUT_W = 6;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [PULSE_W-1:0] cfg_pulses;
  logic [BIN_W-1:0]   cfg_bins;
  logic               cfg_bg_en;
  logic               cfg_cont;
  logic               acc_done;
  logic               bg_done;
  logic               pd_done;
  logic               cap_en;
  logic               spec_acc;
  logic               bg_en;
  logic               pk_en;
  logic [BIN_W-1:0]   pd_bin;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               busy;
  logic               frame_done;
  logic               err;
  logic [2:0]         state;

  int errors = 0;
  int checks = 0;

  // Running event counters sampled on the falling edge.
  int fd_cnt  = 0;
  int bg_cnt  = 0;
  int pk_cnt  = 0;
  int ovl_cnt = 0;

  logic [0:0] exp_q[$];

  lidar_frame_sequencer #(
    .PULSE_W   (PULSE_W),
    .BIN_W     (BIN_W),
    .NUM_BINS  (NUM_BINS),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .abort_i             (abort),
    .cfg_pulses_i        (cfg_pulses),
    .cfg_bins_i          (cfg_bins),
    .cfg_bg_en_i         (cfg_bg_en),
    .cfg_cont_i          (cfg_cont),
    .acc_done_i          (acc_done),
    .bg_done_i           (bg_done),
    .pd_bin_done_i       (pd_done),
    .capture_en_o        (cap_en),
    .spec_acc_ctrl_o     (spec_acc),
    .bg_deduction_en_o   (bg_en),
    .peak_detection_en_o (pk_en),
    .pd_bin_o            (pd_bin),
    .pulse_count_o       (pulse_cnt),
    .busy_o              (busy),
    .frame_done_o        (frame_done),
    .error_o             (err),
    .state_o             (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (bg_en) bg_cnt++;
    if (pk_en) pk_cnt++;
    if ((int'(cap_en) + int'(bg_en) + int'(pk_en)) > 1) ovl_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic start_frame(input int p, input int b, input logic bge);
    cfg_pulses = PULSE_W'(p);
    cfg_bins   = BIN_W'(b);
    cfg_bg_en  = bge;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic acc_pulse();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  task automatic bg_pulse();
    bg_done = 1'b1;
    tick();
    bg_done = 1'b0;
  endtask

  task automatic pd_pulse();
    pd_done = 1'b1;
    tick();
    pd_done = 1'b0;
  endtask

  initial begin
    int fd0, bg0, pk0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_pulses = '0; cfg_bins = '0;
    cfg_bg_en = 1'b0; cfg_cont = 1'b0; acc_done = 1'b0; bg_done = 1'b0; pd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enables", {cap_en, spec_acc, bg_en, pk_en}, 0);
    chk("rst_bin", pd_bin, 0);
    chk("rst_pulses", pulse_cnt, 0);
    chk("rst_done_err", {frame_done, err}, 0);

    // Full frame: 3 pulses, background, 4 bins
    fd0 = fd_cnt;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    start_frame(3, 4, 1'b1);
    chk("f1_state_cap", state, 1);
    chk("f1_cap_en", cap_en, 1);
    chk("f1_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("f1_spec_acc", spec_acc, exp_q.pop_front());
      chk("f1_pulse_cnt", pulse_cnt, i);
      acc_pulse();
      if (i < 2) begin
        chk("f1_still_cap", state, 1);
        tick();
      end
    end
    chk("f1_state_bg", state, 2);
    chk("f1_bg_handover", {cap_en, bg_en, pk_en}, 3'b010);
    chk("f1_pulse_final", pulse_cnt, 3);
    tick();
    bg_pulse();
    chk("f1_state_peak", state, 3);
    chk("f1_peak_handover", {cap_en, bg_en, pk_en}, 3'b001);
    for (int b = 0; b < 4; b++) begin
      chk("f1_pd_bin", pd_bin, b);
      pd_pulse();
    end
    chk("f1_state_done", state, 4);
    chk("f1_frame_done", frame_done, 1);
    chk("f1_pk_off", pk_en, 0);
    tick();
    chk("f1_idle", state, 0);
    chk("f1_fd_low", frame_done, 0);
    chk("f1_not_busy", busy, 0);
    chk("f1_fd_count", fd_cnt - fd0, 1);

    // No background, single pulse, stray acc_done in PEAK
    bg0 = bg_cnt;
    start_frame(1, 2, 1'b0);
    chk("f2_state_cap", state, 1);
    acc_pulse();
    chk("f2_direct_peak", state, 3);
    chk("f2_enables", {cap_en, bg_en, pk_en}, 3'b001);
    acc_pulse();
    chk("f2_stray_acc_state", state, 3);
    chk("f2_stray_acc_bin", pd_bin, 0);
    chk("f2_stray_acc_cnt", pulse_cnt, 1);
    pd_pulse();
    chk("f2_bin1", pd_bin, 1);
    pd_pulse();
    chk("f2_done", state, 4);
    tick();
    chk("f2_idle", state, 0);
    chk("f2_no_bg", bg_cnt - bg0, 0);

    // Illegal configurations
    start_frame(0, 4, 1'b0);
    chk("ill_p0_state", state, 0);
    chk("ill_p0_err", err, 1);
    start_frame(2, 17, 1'b0);
    chk("ill_b17_state", state, 0);
    chk("ill_b17_err", err, 1);
    start_frame(1, 16, 1'b0);
    chk("valid_clears_err", err, 0);
    chk("valid_b16_state", state, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", state, 0);
    chk("abort_cap_off", cap_en, 0);

    // Abort coinciding with the terminal acc_done
    fd0 = fd_cnt; bg0 = bg_cnt; pk0 = pk_cnt;
    start_frame(2, 2, 1'b1);
    acc_pulse();
    chk("ab_pulse1", pulse_cnt, 1);
    acc_done = 1'b1; abort = 1'b1;
    tick();
    acc_done = 1'b0; abort = 1'b0;
    chk("ab_state", state, 0);
    chk("ab_enables", {cap_en, spec_acc, bg_en, pk_en}, 0);
    chk("ab_err_kept", err, 0);
    tick(); tick();
    chk("ab_no_bg_pk_fd", (bg_cnt - bg0) + (pk_cnt - pk0) + (fd_cnt - fd0), 0);

    // Watchdog on withheld bg_done
    start_frame(1, 1, 1'b1);
    acc_pulse();
    chk("wd_in_bg", state, 2);
    n = 1;
    for (int k = 0; k < 200 && state == 3'd2; k++) begin
      tick();
      if (state == 3'd2) n++;
    end
    chk("wd_bg_cycles", n, 63);
    chk("wd_state", state, 0);
    chk("wd_err", err, 1);
    chk("wd_bg_off", bg_en, 0);

    // Continuous mode with ignored start during the frame
    fd0 = fd_cnt;
    cfg_cont = 1'b1;
    start_frame(1, 1, 1'b0);
    chk("ct_state", state, 1);
    chk("ct_err_clr", err, 0);
    start_frame(5, 3, 1'b1);
    chk("ct_start_ignored", state, 1);
    acc_pulse();
    chk("ct_cfg_kept", state, 3);
    pd_pulse();
    chk("ct_done", frame_done, 1);
    tick();
    chk("ct_restart_state", state, 1);
    chk("ct_restart_cap", cap_en, 1);
    chk("ct_restart_cnt", pulse_cnt, 0);
    chk("ct_restart_overwrite", spec_acc, 0);
    chk("ct_fd_low", frame_done, 0);
    cfg_cont = 1'b0;
    acc_pulse();
    chk("ct2_peak", state, 3);
    pd_pulse();
    tick();
    chk("ct2_idle", state, 0);
    chk("ct_fd_count", fd_cnt - fd0, 2);

    // Asynchronous reset mid-frame
    start_frame(2, 2, 1'b0);
    acc_pulse();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_outputs", {cap_en, spec_acc, busy, err}, 0);
    chk("arst_cnt", pulse_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    chk("no_enable_overlap", ovl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
